// File: rtl/spike_dispatcher_if.sv
// Purpose: spike producer -> dispatcher -> MAC array signal bundle.
// Latency: none (wires only).
// Backpressure: spike_ready is the producer-side ready; MAC side has none.
// Ports: start, spike_valid/spike_addr/spike_ready (producer side);
//        source_address/addr_valid/set_mac/clear_mac (MAC side);
//        timestep_done/timestep_count/overflow (status).
// Modports: master = producer/controller side, slave = dispatcher.
interface spike_dispatcher_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic              spike_valid;
    logic [ADDR_W-1:0] spike_addr;
    logic              spike_ready;
    logic [ADDR_W-1:0] source_address;
    logic              addr_valid;
    logic              set_mac;
    logic              clear_mac;
    logic              timestep_done;
    logic [15:0]       timestep_count;
    logic              overflow;

    modport master (
        output start, spike_valid, spike_addr,
        input  spike_ready, source_address, addr_valid, set_mac, clear_mac,
               timestep_done, timestep_count, overflow
    );

    modport slave (
        input  start, spike_valid, spike_addr,
        output spike_ready, source_address, addr_valid, set_mac, clear_mac,
               timestep_done, timestep_count, overflow
    );
endinterface

// File: rtl/spike_dispatcher.sv
// Purpose: buffers spike addresses and sequences set/dispatch/clear strobes for the MAC array.
// Latency: 1 cycle push-to-bus when the FIFO is empty during RUN; all outputs registered.
// Backpressure: spike_ready = !full; a spike offered while full is dropped and sets sticky overflow.
//
// Ports: CLK, RST_N (async active-low), bus (spike_dispatcher_if.slave).
// Option: define SPIKE_DISPATCH_GAP_EN to insert a NULL_ADDR cycle after every
//         dispatched spike (max 1 spike per 2 cycles); undefined allows back-to-back pops.
// FIFO_DEPTH must be a power of 2 and at least 2.
module spike_dispatcher #(
    parameter int                ADDR_W       = 12,
    parameter int                FIFO_DEPTH   = 16,
    parameter int                INIT_CYCLES  = 4,
    parameter int                RUN_CYCLES   = 64,
    parameter int                CLEAR_CYCLES = 2,
    parameter logic [ADDR_W-1:0] NULL_ADDR    = {ADDR_W{1'b1}}
) (
    input  logic               CLK,
    input  logic               RST_N,
    spike_dispatcher_if.slave  bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int MAX_A = (INIT_CYCLES > RUN_CYCLES) ? INIT_CYCLES : RUN_CYCLES;
    localparam int MAX_C = (MAX_A > CLEAR_CYCLES) ? MAX_A : CLEAR_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN, CLEAR} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;

    // Spike FIFO storage and pointers
    logic [ADDR_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       occ;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop_win;
    logic              gap_hold;
    logic              pop;

    // Depth is a power of 2, so the occupancy MSB alone means "full".
    assign full            = occ[AW];
    assign empty           = (occ == '0);
    assign bus.spike_ready = !full;
    assign push            = bus.spike_valid && !full;

    // A pop at this edge feeds the bus for the cycle that follows, so the
    // window is "next cycle is a RUN cycle": the INIT->RUN edge, every RUN
    // edge that stays in RUN, and a CLEAR exit that goes straight back to RUN.
    always_comb begin
        pop_win = 1'b0;
        case (state)
            INIT:    pop_win = (cnt == '0);
            RUN:     pop_win = (cnt != '0);
            CLEAR:   pop_win = (cnt == '0) && bus.start;
            default: pop_win = 1'b0;
        endcase
    end

`ifdef SPIKE_DISPATCH_GAP_EN
    // Skip one slot after each dispatched spike so repeated addresses still toggle the bus.
    assign gap_hold = bus.addr_valid;
`else
    assign gap_hold = 1'b0;
`endif

    assign pop = pop_win && !empty && !gap_hold;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= bus.spike_addr;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state              <= IDLE;
            cnt                <= '0;
            bus.source_address <= NULL_ADDR;
            bus.addr_valid     <= 1'b0;
            bus.set_mac        <= 1'b0;
            bus.clear_mac      <= 1'b0;
            bus.timestep_done  <= 1'b0;
            bus.timestep_count <= '0;
            bus.overflow       <= 1'b0;
        end else begin
            bus.timestep_done  <= 1'b0;
            bus.source_address <= pop ? mem[rd_ptr] : NULL_ADDR;
            bus.addr_valid     <= pop;

            // A drop in the same cycle as the restart still counts as an overflow.
            if (state == IDLE && bus.start) begin
                bus.overflow <= bus.spike_valid && full;
            end else if (bus.spike_valid && full) begin
                bus.overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    bus.set_mac   <= 1'b0;
                    bus.clear_mac <= 1'b0;
                    if (bus.start) begin
                        state              <= INIT;
                        bus.set_mac        <= 1'b1;
                        cnt                <= CW'(INIT_CYCLES - 1);
                        bus.timestep_count <= '0;
                    end
                end
                INIT: begin
                    if (cnt == '0) begin
                        state       <= RUN;
                        bus.set_mac <= 1'b0;
                        cnt         <= CW'(RUN_CYCLES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state             <= CLEAR;
                        bus.clear_mac     <= 1'b1;
                        bus.timestep_done <= 1'b1;
                        cnt               <= CW'(CLEAR_CYCLES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == '0) begin
                        bus.clear_mac      <= 1'b0;
                        bus.timestep_count <= bus.timestep_count + 16'd1;
                        if (bus.start) begin
                            state <= RUN;
                            cnt   <= CW'(RUN_CYCLES - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
